// File: rtl/seq_divider_if.sv
// Request/result bundle between a client and the iterative divider.
// start is a one-cycle request taken only while the divider is idle or done;
// done stays high with quotient/remainder/div_by_zero valid until the next accepted start.
interface seq_divider_if #(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, restore
// folded into the same cycle, held done flag and divide-by-zero shortcut.
module seq_divider #(
    parameter int N = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    seq_divider_if.slave bus,
    output logic [1:0]  dbg_state
);
    localparam int CW = $clog2(N + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] CNT_INIT = CW'(N);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [1:0]    state_q, state_d;
    logic [N:0]    a_q, a_d;
    logic [N-1:0]  q_q, q_d;
    logic [N-1:0]  m_q, m_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dbz_q, dbz_d;

    logic [N:0]    shifted;
    logic [N:0]    trial;
    logic          a_msb_unused;

    // A never exceeds M after a step, so its top bit carries no information
    // into the next shift; it only exists to keep the trial subtract N+1 wide.
    assign a_msb_unused = a_q[N];

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;
        shifted = {a_q[N-1:0], q_q[N-1]};
        trial   = shifted - {1'b0, m_q};

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    if (bus.divisor != '0) begin
                        q_d     = bus.dividend;
                        m_d     = bus.divisor;
                        a_d     = '0;
                        cnt_d   = CNT_INIT;
                        dbz_d   = 1'b0;
                        state_d = S_ITER;
                    end else begin
                        q_d     = '1;
                        a_d     = {1'b0, bus.dividend};
                        dbz_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_ITER: begin
                if (trial[N]) begin
                    a_d = shifted;
                    q_d = {q_q[N-2:0], 1'b0};
                end else begin
                    a_d = trial;
                    q_d = {q_q[N-2:0], 1'b1};
                end
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.busy        = (state_q == S_ITER);
    assign bus.done        = (state_q == S_DONE);
    assign bus.quotient    = q_q;
    assign bus.remainder   = a_q[N-1:0];
    assign bus.div_by_zero = dbz_q;
    assign dbg_state       = state_q;
endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: reset, divides, boundaries, divide by zero,
// start while busy, back-to-back, mid-operation reset and a random sweep.
module tb_seq_divider;
    localparam int N = 8;

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;
    int         pass_cnt;
    int         total_cnt;

    seq_divider_if #(.N(N)) dif ();

    seq_divider #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (dif.slave),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present operands at a falling edge, let the rising edge accept them,
    // and return at the next falling edge with start dropped.
    task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b);
        dif.start    = 1'b1;
        dif.dividend = a;
        dif.divisor  = b;
        @(negedge clk);
        dif.start    = 1'b0;
    endtask

    task automatic wait_done(output int busy_cycles, output bit ok);
        busy_cycles = 0;
        ok          = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (dif.done) begin
                ok = 1'b1;
                break;
            end
            if (dif.busy) busy_cycles++;
            @(negedge clk);
        end
    endtask

    task automatic do_div(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] exp_q, input logic [N-1:0] exp_r);
        int bc;
        bit ok;
        launch(a, b);
        wait_done(bc, ok);
        total_cnt++;
        if (!ok || bc != N) $display("FAIL %s latency: done=%0b busy_cycles=%0d expected done=1 busy_cycles=%0d", name, ok, bc, N);
        else pass_cnt++;
        total_cnt++;
        if (dif.quotient !== exp_q || dif.remainder !== exp_r || dif.div_by_zero !== 1'b0)
            $display("FAIL %s result: q=%0d r=%0d dbz=%0b expected q=%0d r=%0d dbz=0",
                     name, dif.quotient, dif.remainder, dif.div_by_zero, exp_q, exp_r);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        dif.start = 1'b0;
        dif.dividend = '0;
        dif.divisor = '0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (dif.busy !== 1'b0 || dif.done !== 1'b0 || dif.quotient !== 8'd0 ||
            dif.remainder !== 8'd0 || dif.div_by_zero !== 1'b0 || dbg_state !== 2'd0)
            $display("FAIL reset: busy=%0b done=%0b q=%0d r=%0d dbz=%0b st=%0d expected all 0",
                     dif.busy, dif.done, dif.quotient, dif.remainder, dif.div_by_zero, dbg_state);
        else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        do_div("basic_100_7", 8'd100, 8'd7, 8'd14, 8'd2);
        repeat (10) @(negedge clk);
        total_cnt++;
        if (dif.done !== 1'b1 || dif.busy !== 1'b0 || dif.quotient !== 8'd14 || dif.remainder !== 8'd2)
            $display("FAIL basic_hold: done=%0b busy=%0b q=%0d r=%0d expected done=1 busy=0 q=14 r=2",
                     dif.done, dif.busy, dif.quotient, dif.remainder);
        else pass_cnt++;
    endtask

    task automatic test_boundaries();
        do_div("max_by_1", 8'd255, 8'd1, 8'd255, 8'd0);
        do_div("small_by_big", 8'd5, 8'd9, 8'd0, 8'd5);
        do_div("max_by_max", 8'd255, 8'd255, 8'd1, 8'd0);
    endtask

    task automatic test_div_by_zero();
        launch(8'd77, 8'd0);
        total_cnt++;
        if (dif.done !== 1'b1 || dif.busy !== 1'b0 || dif.quotient !== 8'hFF ||
            dif.remainder !== 8'd77 || dif.div_by_zero !== 1'b1)
            $display("FAIL div_zero: done=%0b busy=%0b q=%0h r=%0d dbz=%0b expected done=1 busy=0 q=ff r=77 dbz=1",
                     dif.done, dif.busy, dif.quotient, dif.remainder, dif.div_by_zero);
        else pass_cnt++;
        // A normal divide started from this DONE must clear the flag.
        do_div("after_zero", 8'd9, 8'd2, 8'd4, 8'd1);
    endtask

    task automatic test_start_while_busy();
        int bc;
        bit ok;
        bit pulsed;
        bc = 0;
        ok = 1'b0;
        pulsed = 1'b0;
        launch(8'd100, 8'd7);
        for (int i = 0; i < 40; i++) begin
            if (dif.done) begin
                ok = 1'b1;
                break;
            end
            if (dif.busy) bc++;
            if (bc == 3 && !pulsed) begin
                dif.start = 1'b1;
                dif.dividend = 8'd200;
                dif.divisor = 8'd3;
                pulsed = 1'b1;
            end else begin
                dif.start = 1'b0;
            end
            @(negedge clk);
        end
        dif.start = 1'b0;
        total_cnt++;
        if (!ok || bc != N || dif.quotient !== 8'd14 || dif.remainder !== 8'd2)
            $display("FAIL start_busy: done=%0b busy_cycles=%0d q=%0d r=%0d expected done=1 busy_cycles=8 q=14 r=2",
                     ok, bc, dif.quotient, dif.remainder);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int bc;
        bit ok;
        do_div("b2b_first", 8'd100, 8'd7, 8'd14, 8'd2);
        launch(8'd200, 8'd3);
        total_cnt++;
        if (dif.done !== 1'b0 || dif.busy !== 1'b1)
            $display("FAIL b2b_accept: done=%0b busy=%0b expected done=0 busy=1", dif.done, dif.busy);
        else pass_cnt++;
        wait_done(bc, ok);
        total_cnt++;
        if (!ok || bc != N || dif.quotient !== 8'd66 || dif.remainder !== 8'd2)
            $display("FAIL b2b_second: done=%0b busy_cycles=%0d q=%0d r=%0d expected done=1 busy_cycles=8 q=66 r=2",
                     ok, bc, dif.quotient, dif.remainder);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_op();
        launch(8'd100, 8'd7);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (dif.busy !== 1'b0 || dif.done !== 1'b0 || dif.quotient !== 8'd0 ||
            dif.remainder !== 8'd0 || dif.div_by_zero !== 1'b0)
            $display("FAIL reset_mid: busy=%0b done=%0b q=%0d r=%0d dbz=%0b expected all 0",
                     dif.busy, dif.done, dif.quotient, dif.remainder, dif.div_by_zero);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (dbg_state !== 2'd0 || dif.done !== 1'b0 || dif.busy !== 1'b0)
            $display("FAIL reset_idle: state=%0d done=%0b busy=%0b expected state=0 done=0 busy=0",
                     dbg_state, dif.done, dif.busy);
        else pass_cnt++;
        do_div("after_reset", 8'd100, 8'd7, 8'd14, 8'd2);
    endtask

    task automatic test_random_sweep();
        logic [N-1:0] a;
        logic [N-1:0] b;
        int bc;
        bit ok;
        int bad;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            a = N'($urandom_range(0, 255));
            b = N'($urandom_range(1, 255));
            launch(a, b);
            wait_done(bc, ok);
            total_cnt++;
            if (!ok || dif.quotient !== a / b || dif.remainder !== a % b ||
                (16'(dif.quotient) * 16'(b) + 16'(dif.remainder)) != 16'(a) || !(dif.remainder < b)) begin
                if (bad < 10)
                    $display("FAIL sweep %0d/%0d: done=%0b q=%0d r=%0d expected q=%0d r=%0d",
                             a, b, ok, dif.quotient, dif.remainder, a / b, a % b);
                bad++;
            end else pass_cnt++;
        end
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        test_reset();
        test_basic();
        test_boundaries();
        test_div_by_zero();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_op();
        test_random_sweep();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
